color_shape_classifier: RTL and testbench

Per-frame color and shape classifier for the camera image path. Consumes RGB332 pixels with their VGA coordinates, counts red-dominant and blue-dominant pixels per horizontal band, and at each frame boundary emits a 2-bit color code, a 2-bit shape code and a one-cycle valid strobe to the Arduino-facing result register. It is the parametrised successor of the single-bit red/blue frame detector, adding pixel qualification, banded counts, thresholds, saturation and a defined frame handshake.

---
 rtl/classifier_pkg.sv | 43 ++++
 rtl/color_shape_classifier_if.sv | 24 ++
 rtl/band_counter.sv | 23 ++
 rtl/color_shape_classifier.sv | 164 ++++++++++++++++
 tb/tb_color_shape_classifier.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/classifier_pkg.sv
// classifier_pkg: shared definitions for color_shape_classifier.
//   color_t     - result color codes (00 none, 01 red, 10 blue)
//   shape_t     - result shape codes (00 none, 01 square, 10 triangle, 11 diamond)
//   state_t     - frame FSM states
//   pix_class_t - per-pixel dominance class
//   classify_pixel() - RGB332 red/blue dominance test on the two top red bits
package classifier_pkg;

   typedef enum logic [1:0] {
      COLOR_NONE = 2'b00,
      COLOR_RED  = 2'b01,
      COLOR_BLUE = 2'b10
   } color_t;

   typedef enum logic [1:0] {
      SHAPE_NONE     = 2'b00,
      SHAPE_SQUARE   = 2'b01,
      SHAPE_TRIANGLE = 2'b10,
      SHAPE_DIAMOND  = 2'b11
   } shape_t;

   typedef enum logic [1:0] {
      ST_SKIP,
      ST_ACCUM,
      ST_DECIDE,
      ST_EMIT
   } state_t;

   typedef enum logic [1:0] {
      PIX_NONE,
      PIX_RED,
      PIX_BLUE
   } pix_class_t;

   function automatic pix_class_t classify_pixel(input logic [1:0] red_hi, input logic [1:0] blue);
      if (red_hi > blue)
         return PIX_RED;
      else if (blue > red_hi)
         return PIX_BLUE;
      return PIX_NONE;
   endfunction

endpackage

// File: rtl/color_shape_classifier_if.sv
// color_shape_classifier_if: camera pixel stream in, frame result out.
//   PIXEL_IN[7:0], PIXEL_VALID, VGA_PIXEL_X/Y[9:0], VGA_VSYNC_NEG : camera side -> classifier
//   RESULT_COLOR[1:0], RESULT_SHAPE[1:0], RESULT_VALID           : classifier -> result register
// master = camera/result-register side, slave = classifier.
interface color_shape_classifier_if;
   logic [7:0] PIXEL_IN;
   logic       PIXEL_VALID;
   logic [9:0] VGA_PIXEL_X;
   logic [9:0] VGA_PIXEL_Y;
   logic       VGA_VSYNC_NEG;
   logic [1:0] RESULT_COLOR;
   logic [1:0] RESULT_SHAPE;
   logic       RESULT_VALID;

   modport master (
      output PIXEL_IN, PIXEL_VALID, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
      input  RESULT_COLOR, RESULT_SHAPE, RESULT_VALID
   );

   modport slave (
      input  PIXEL_IN, PIXEL_VALID, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
      output RESULT_COLOR, RESULT_SHAPE, RESULT_VALID
   );
endinterface

// File: rtl/band_counter.sv
// band_counter: saturating up-counter for one band/color.
//   CLK, RESET (async, active-high)
//   clear : restart the count; if inc is also set the count restarts at 1
//   inc   : add one, holding at all-ones
//   count : current value
module band_counter #(
   parameter int CNT_W = 15
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         count <= '0;
      else if (clear)
         count <= inc ? CNT_W'(1) : '0;
      else if (inc && count != '1)
         count <= count + CNT_W'(1);
   end
endmodule

// File: rtl/color_shape_classifier.sv
// color_shape_classifier: per-frame red/blue color and shape classifier.
//   CLK, RESET (async, active-high)
//   bus (slave): pixel stream + VSYNC in, RESULT_COLOR/RESULT_SHAPE/RESULT_VALID out.
// A VSYNC rising edge ends a frame; the result appears three edges later with
// a one-cycle RESULT_VALID. The partial frame after reset is discarded.
// Build option: define CLASSIFIER_SHAPE_EN for per-band counters and the shape
// rule; otherwise one red and one blue counter and RESULT_SHAPE stays 00.
module color_shape_classifier
   import classifier_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 176,
   parameter int SCREEN_HEIGHT = 144,
   parameter int NUM_BANDS     = 3,
   parameter int CNT_W         = 15,
   parameter int COLOR_THRESH  = 2000,
   parameter int SHAPE_MARGIN  = 300
) (
   input logic                     CLK,
   input logic                     RESET,
   color_shape_classifier_if.slave bus
);
   localparam int BAND_HEIGHT = SCREEN_HEIGHT / NUM_BANDS;
`ifdef CLASSIFIER_SHAPE_EN
   localparam int NB = NUM_BANDS;
`else
   localparam int NB = 1;
`endif
   localparam int               SUM_W  = CNT_W + 2;
   localparam logic [9:0]       X_LIM  = 10'(SCREEN_WIDTH);
   localparam logic [9:0]       Y_LIM  = 10'(SCREEN_HEIGHT);
   localparam logic [SUM_W-1:0] THRESH = SUM_W'(COLOR_THRESH);

   state_t           state;
   logic             vs_q;
   logic             frame_end;
   logic             cnt_clr;
   logic             pix_ok;
   pix_class_t       pclass;
   logic [CNT_W-1:0] red_cnt  [NB];
   logic [CNT_W-1:0] blue_cnt [NB];
   logic [CNT_W-1:0] red_h    [NB];
   logic [CNT_W-1:0] blue_h   [NB];
   logic [SUM_W-1:0] sum_r, sum_b;
   color_t           color_d, color_q;
   shape_t           shape_d, shape_q;

   assign frame_end = !vs_q && bus.VGA_VSYNC_NEG;
   // Frame ends during DECIDE/EMIT are ignored, so counters keep the new frame.
   assign cnt_clr   = frame_end && (state == ST_SKIP || state == ST_ACCUM);
   assign pix_ok    = bus.PIXEL_VALID && (bus.VGA_PIXEL_X < X_LIM) && (bus.VGA_PIXEL_Y < Y_LIM);
   assign pclass    = classify_pixel(bus.PIXEL_IN[7:6], bus.PIXEL_IN[1:0]);

   for (genvar b = 0; b < NB; b++) begin : g_band
      logic above_lo, below_hi, in_band;
      // y >= lo written as y+1 > lo so band 0 is not a constant y >= 0 compare.
      assign above_lo = ({1'b0, bus.VGA_PIXEL_Y} + 11'd1) > 11'(b * BAND_HEIGHT);
      // The last band also takes the leftover rows below NB*BAND_HEIGHT.
      if (b == NB - 1) begin : g_last
         assign below_hi = 1'b1;
      end else begin : g_mid
         assign below_hi = bus.VGA_PIXEL_Y < 10'((b + 1) * BAND_HEIGHT);
      end
      assign in_band = pix_ok && above_lo && below_hi;

      band_counter #(.CNT_W(CNT_W)) u_red (
         .CLK   (CLK),
         .RESET (RESET),
         .clear (cnt_clr),
         .inc   (in_band && pclass == PIX_RED),
         .count (red_cnt[b])
      );
      band_counter #(.CNT_W(CNT_W)) u_blue (
         .CLK   (CLK),
         .RESET (RESET),
         .clear (cnt_clr),
         .inc   (in_band && pclass == PIX_BLUE),
         .count (blue_cnt[b])
      );
   end

   always_comb begin
      sum_r = '0;
      sum_b = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         sum_r = sum_r + SUM_W'(red_h[i]);
         sum_b = sum_b + SUM_W'(blue_h[i]);
      end
      if (sum_r > THRESH && sum_r >= sum_b)
         color_d = COLOR_RED;
      else if (sum_b > THRESH && sum_b > sum_r)
         color_d = COLOR_BLUE;
      else
         color_d = COLOR_NONE;
   end

`ifdef CLASSIFIER_SHAPE_EN
   localparam logic [SUM_W-1:0] MARGIN = SUM_W'(SHAPE_MARGIN);
   logic [SUM_W-1:0] top_c, mid_c, bot_c;

   always_comb begin
      if (color_d == COLOR_BLUE) begin
         top_c = SUM_W'(blue_h[0]);
         mid_c = SUM_W'(blue_h[NB/2]);
         bot_c = SUM_W'(blue_h[NB-1]);
      end else begin
         top_c = SUM_W'(red_h[0]);
         mid_c = SUM_W'(red_h[NB/2]);
         bot_c = SUM_W'(red_h[NB-1]);
      end
      if (color_d == COLOR_NONE)
         shape_d = SHAPE_NONE;
      else if (mid_c > top_c + MARGIN && mid_c > bot_c + MARGIN)
         shape_d = SHAPE_DIAMOND;
      else if (bot_c > top_c + MARGIN && mid_c > top_c)
         shape_d = SHAPE_TRIANGLE;
      else
         shape_d = SHAPE_SQUARE;
   end
`else
   assign shape_d = SHAPE_NONE;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state            <= ST_SKIP;
         vs_q             <= 1'b1;
         red_h            <= '{default: '0};
         blue_h           <= '{default: '0};
         color_q          <= COLOR_NONE;
         shape_q          <= SHAPE_NONE;
         bus.RESULT_COLOR <= '0;
         bus.RESULT_SHAPE <= '0;
         bus.RESULT_VALID <= 1'b0;
      end else begin
         vs_q             <= bus.VGA_VSYNC_NEG;
         bus.RESULT_VALID <= 1'b0;
         case (state)
            ST_SKIP: begin
               if (frame_end)
                  state <= ST_ACCUM;
            end
            ST_ACCUM: begin
               if (frame_end) begin
                  red_h  <= red_cnt;
                  blue_h <= blue_cnt;
                  state  <= ST_DECIDE;
               end
            end
            ST_DECIDE: begin
               color_q <= color_d;
               shape_q <= shape_d;
               state   <= ST_EMIT;
            end
            ST_EMIT: begin
               bus.RESULT_COLOR <= color_q;
               bus.RESULT_SHAPE <= shape_q;
               bus.RESULT_VALID <= 1'b1;
               state            <= ST_ACCUM;
            end
            default: state <= ST_SKIP;
         endcase
      end
   end
endmodule

// File: tb/tb_color_shape_classifier.sv
// tb_color_shape_classifier: directed-frame bench for color_shape_classifier.
// Runs a reduced 16x14 screen (3 bands of 4 rows, rows 12-13 fold into band 2),
// 8-bit counters, threshold 20 and margin 5 so every frame stays short.
// A behavioural model predicts each frame result and its strobe cycle; a
// negedge process compares valid/color/shape every cycle, and literal checks
// pin the expected result of each directed frame.
`timescale 1ns/1ps
module tb_color_shape_classifier;
   localparam int W     = 16;
   localparam int H     = 14;
   localparam int NB    = 3;
   localparam int BH    = H / NB;
   localparam int CNT_W = 8;
   localparam int MAXC  = 255;
   localparam int THR   = 20;
   localparam int MG    = 5;
`ifdef CLASSIFIER_SHAPE_EN
   localparam bit SHAPE_ON = 1'b1;
`else
   localparam bit SHAPE_ON = 1'b0;
`endif

   localparam int M_RED       = 0;
   localparam int M_BLUE_HALF = 1;
   localparam int M_RED_LOW   = 2;
   localparam int M_RED_MID   = 3;
   localparam int M_RED20     = 4;
   localparam int M_SPLIT     = 5;
   localparam int M_BLUE      = 6;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   // model state
   int mr [NB];
   int mb [NB];
   int tr, tb;
   bit armed = 1'b0;
   bit pend = 1'b0;
   int due = 0, pend_c = 0, pend_s = 0;
   int hold_c = 0, hold_s = 0;

   color_shape_classifier_if bus();

   color_shape_classifier #(
      .SCREEN_WIDTH  (W),
      .SCREEN_HEIGHT (H),
      .NUM_BANDS     (NB),
      .CNT_W         (CNT_W),
      .COLOR_THRESH  (THR),
      .SHAPE_MARGIN  (MG)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NB; i++) begin
         mr[i] = 0;
         mb[i] = 0;
      end
      tr = 0;
      tb = 0;
   endfunction

   function automatic void model_px(input bit v, input int px, input int x, input int y);
      int band, r, b;
      if (!v || x >= W || y >= H) return;
      r = (px >> 6) & 3;
      b = px & 3;
      band = y / BH;
      if (band > NB - 1) band = NB - 1;
      if (r > b) begin
         mr[band] = sat(mr[band] + 1);
         tr = sat(tr + 1);
      end else if (b > r) begin
         mb[band] = sat(mb[band] + 1);
         tb = sat(tb + 1);
      end
   endfunction

   function automatic void model_decide(output int c, output int s);
      int R, B, t, m, bo;
      if (SHAPE_ON) begin
         R = mr[0] + mr[1] + mr[2];
         B = mb[0] + mb[1] + mb[2];
      end else begin
         R = tr;
         B = tb;
      end
      if (R > THR && R >= B) c = 1;
      else if (B > THR && B > R) c = 2;
      else c = 0;
      s = 0;
      if (SHAPE_ON && c != 0) begin
         t  = (c == 1) ? mr[0]      : mb[0];
         m  = (c == 1) ? mr[NB/2]   : mb[NB/2];
         bo = (c == 1) ? mr[NB-1]   : mb[NB-1];
         if (m > t + MG && m > bo + MG) s = 3;
         else if (bo > t + MG && m > t) s = 2;
         else s = 1;
      end
   endfunction

   function automatic void pattern(input int mode, input int x, input int y,
                                   output bit v, output int px);
      v = 1'b1;
      case (mode)
         M_RED:       px = 'hE0;
         M_BLUE_HALF: begin v = (x % 2 == 0); px = v ? 'h03 : 'hE0; end
         M_RED_LOW:   px = (y >= 4) ? 'hE0 : 'h00;
         M_RED_MID:   px = (y >= 4 && y < 8) ? 'hE0 : 'h00;
         M_RED20:     px = (y == 0 || (y == 1 && x < 4)) ? 'hE0 : 'h00;
         M_SPLIT:     px = (x < 8) ? 'hE0 : 'h03;
         M_BLUE:      px = 'h03;
         default:     px = 'h00;
      endcase
   endfunction

   task automatic drive(input bit v, input int px, input int x, input int y);
      @(posedge clk); #1;
      bus.PIXEL_VALID = v;
      bus.PIXEL_IN    = 8'(px);
      bus.VGA_PIXEL_X = 10'(x);
      bus.VGA_PIXEL_Y = 10'(y);
      model_px(v, px, x, y);
   endtask

   task automatic send_frame(input int mode);
      bit v;
      int px;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            pattern(mode, x, y, v, px);
            drive(v, px, x, y);
         end
   endtask

   // VSYNC rises this cycle; optionally a red pixel at (0,0) rides along
   // (it belongs to the next frame), optionally reset lands in DECIDE.
   task automatic end_frame(input bit carry, input bit rst_decide);
      int c, s;
      @(posedge clk); #1;
      bus.VGA_VSYNC_NEG = 1'b1;
      bus.PIXEL_VALID   = carry;
      bus.PIXEL_IN      = 8'hE0;
      bus.VGA_PIXEL_X   = '0;
      bus.VGA_PIXEL_Y   = '0;
      if (armed) begin
         model_decide(c, s);
         pend   = 1'b1;
         due    = cyc + 3;
         pend_c = c;
         pend_s = s;
      end
      model_clear();
      armed = 1'b1;
      if (carry) model_px(1'b1, 'hE0, 0, 0);
      if (rst_decide) begin
         @(posedge clk); #1;
         bus.PIXEL_VALID = 1'b0;
         rst    = 1'b1;
         pend   = 1'b0;
         hold_c = 0;
         hold_s = 0;
         armed  = 1'b0;
         model_clear();
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
      end
      repeat (5) begin
         @(posedge clk); #1;
         bus.PIXEL_VALID = 1'b0;
      end
      bus.VGA_VSYNC_NEG = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic expect_result(input string name, input int c, input int s);
      chk({name, "_color"}, int'(bus.RESULT_COLOR), c);
      chk({name, "_shape"}, int'(bus.RESULT_SHAPE), SHAPE_ON ? s : 0);
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      bit ev;
      ev = pend && (cyc == due);
      if (ev) begin
         hold_c = pend_c;
         hold_s = pend_s;
         pend   = 1'b0;
      end
      chk("strobe", int'(bus.RESULT_VALID), int'(ev));
      chk("color",  int'(bus.RESULT_COLOR), hold_c);
      chk("shape",  int'(bus.RESULT_SHAPE), hold_s);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      rst               = 1'b1;
      bus.VGA_VSYNC_NEG = 1'b1;
      bus.PIXEL_VALID   = 1'b0;
      bus.PIXEL_IN      = '0;
      bus.VGA_PIXEL_X   = '0;
      bus.VGA_PIXEL_Y   = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_valid", int'(bus.RESULT_VALID), 0);
      expect_result("reset", 0, 0);
      @(posedge clk); #1;
      bus.VGA_VSYNC_NEG = 1'b0;

      send_frame(M_RED);       end_frame(1'b0, 1'b0); expect_result("skip_first", 0, 0);
      send_frame(M_RED);       end_frame(1'b0, 1'b0); expect_result("red_full", 1, 1);
      send_frame(M_BLUE_HALF); end_frame(1'b0, 1'b0); expect_result("blue_half_valid", 2, 1);
      send_frame(M_RED_LOW);   end_frame(1'b0, 1'b0); expect_result("triangle", 1, 2);
      send_frame(M_RED_MID);   end_frame(1'b1, 1'b0); expect_result("diamond", 1, 3);

      // carried pixel + 20 in-range red = 21 > threshold; X=16 and Y=14 ignored
      send_frame(M_RED20);
      drive(1'b1, 'hE0, W, 0);
      drive(1'b1, 'hE0, 0, H);
      end_frame(1'b0, 1'b0); expect_result("carry_21", 1, 1);

      send_frame(M_RED20);
      drive(1'b1, 'hE0, W, 0);
      drive(1'b1, 'hE0, 0, H);
      end_frame(1'b0, 1'b0); expect_result("thresh_20", 0, 0);

      send_frame(M_SPLIT);     end_frame(1'b0, 1'b0); expect_result("tie_red", 1, 1);

      // 260 red then 300 blue in one band: saturated counts tie -> red
      for (int i = 0; i < 260; i++) drive(1'b1, 'hE0, 0, 0);
      for (int i = 0; i < 300; i++) drive(1'b1, 'h03, 0, 0);
      end_frame(1'b0, 1'b0); expect_result("saturate", 1, 1);

      send_frame(M_BLUE);      end_frame(1'b0, 1'b1); expect_result("reset_in_decide", 0, 0);
      send_frame(M_RED);       end_frame(1'b0, 1'b0); expect_result("skip_after_reset", 0, 0);
      send_frame(M_BLUE);      end_frame(1'b0, 1'b0); expect_result("blue_full", 2, 1);

      repeat (4) drive(1'b0, 0, 0, 0);
      chk("strobe_pending", int'(pend), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
